// File: rtl/max7219_display_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// max7219_display_ctrl
//
// Sequences display writes from a six-digit BCD clock value. It issues one
// configuration write, followed by one write per digit, to the downstream
// max7219_settings block.
//
// The time is snapshotted into a shadow register at frame start, so a frame
// never mixes old and new digits. Refresh and config requests that arrive
// while a write is in flight are queued as single pending flags and coalesce.
// Handshake failures (NACK or timeout) set a sticky error.
//
// Optional feature macro: DISPLAY_DP_BLINK_EN
//   defined   : segment bit 7 of digits 2 and 4 follows i_blink, which is
//               captured with the time snapshot.
//   undefined : segment bit 7 is always 0 and i_blink is ignored.
//
// Ports
//   i_clk, i_reset_n  clock and asynchronous active-low reset
//   i_time_bcd        BCD digits, nibble k drives digit k (digit 0 = rightmost)
//   i_refresh         request a digit frame (level, sampled every cycle)
//   i_config_update   request a config write (level, sampled every cycle)
//   i_blink           separator decimal-point state (macro build only)
//   o_busy            high whenever the sequencer is not idle
//   o_error           sticky handshake-failure flag, cleared only by reset
//   o_stb             write strobe to the settings block
//   i_busy, i_ack     handshake returned by the settings block
//   o_write_config    selects a config write instead of a digit write
//   o_digit           digit index of the current write
//   o_segment         {dp, 3'b000, nibble} for the current digit
// -----------------------------------------------------------------------------
module max7219_display_ctrl #(
    parameter int NUM_DIGITS     = 6,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic [4*NUM_DIGITS-1:0] i_time_bcd,
    input  logic                    i_refresh,
    input  logic                    i_config_update,
    input  logic                    i_blink,
    output logic                    o_busy,
    output logic                    o_error,
    output logic                    o_stb,
    input  logic                    i_busy,
    input  logic                    i_ack,
    output logic                    o_write_config,
    output logic [2:0]              o_digit,
    output logic [7:0]              o_segment
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CFG_REQ  = 3'd1;
    localparam logic [2:0] ST_CFG_WAIT = 3'd2;
    localparam logic [2:0] ST_DIG_REQ  = 3'd3;
    localparam logic [2:0] ST_DIG_WAIT = 3'd4;

    localparam int         TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

    logic [2:0]              state_q, state_d;
    logic                    init_q;
    logic                    cfg_pend_q, cfg_pend_d;
    logic                    frame_pend_q, frame_pend_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [2:0]              idx_q, idx_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic                    error_q, error_d;
    logic                    stb_q, stb_d;
    logic                    busy_q, busy_d;
    logic                    write_config_q, write_config_d;
    logic [2:0]              digit_q, digit_d;
    logic [7:0]              segment_q, segment_d;
    logic                    cfg_start, frame_start, timed_out;
    logic                    dp_d;

`ifdef DISPLAY_DP_BLINK_EN
    logic blink_q, blink_d;
`else
    logic unused_blink;
    assign unused_blink = i_blink;
`endif

    // Selects the nibble for one digit. The most significant digit shows
    // Code-B blank (0xF) instead of a leading zero; 0xA-0xF pass unchanged.
    function automatic logic [3:0] pick_nibble(input logic [4*NUM_DIGITS-1:0] t,
                                               input logic [2:0]              idx);
        logic [3:0] nib;
        nib = 4'h0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == 3'(k)) nib = t[4*k +: 4];
        end
        if (idx == LAST_IDX && nib == 4'h0) nib = 4'hF;
        return nib;
    endfunction

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        shadow_d    = shadow_q;
        idx_d       = idx_q;
        error_d     = error_q;
        cfg_start   = 1'b0;
        frame_start = 1'b0;
`ifdef DISPLAY_DP_BLINK_EN
        blink_d     = blink_q;
`endif
        // Only meaningful outside IDLE, where the counter is running.
        timed_out = (tmo_q == TMO_LAST);

        case (state_q)
            ST_IDLE: begin
                // Config outranks a frame, so a config request raised mid-frame
                // runs before the next frame.
                if (cfg_pend_q) begin
                    cfg_start = 1'b1;
                    state_d   = ST_CFG_REQ;
                end else if (frame_pend_q) begin
                    frame_start = 1'b1;
                    shadow_d    = i_time_bcd;
`ifdef DISPLAY_DP_BLINK_EN
                    blink_d     = i_blink;
`endif
                    idx_d       = 3'd0;
                    state_d     = ST_DIG_REQ;
                end
            end
            ST_CFG_REQ, ST_DIG_REQ: begin
                if (i_busy) begin
                    state_d = (state_q == ST_CFG_REQ) ? ST_CFG_WAIT : ST_DIG_WAIT;
                end else if (timed_out) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_CFG_WAIT: begin
                if (!i_busy) begin
                    if (!i_ack) error_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (timed_out) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DIG_WAIT: begin
                // A NACKed digit still counts as written; the frame moves on.
                if (!i_busy) begin
                    if (!i_ack) error_d = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ST_DIG_REQ;
                    end
                end else if (timed_out) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Requests are set-dominant, so a request seen in the same cycle that
        // a write starts is still queued. Right after reset the block queues
        // one config write and one frame on its own.
        cfg_pend_d   = (cfg_pend_q & ~cfg_start) | i_config_update | ~init_q;
        frame_pend_d = (frame_pend_q & ~frame_start) | i_refresh | ~init_q;

        // The phase counter restarts on every state change and idles at zero.
        if (state_d != state_q || state_d == ST_IDLE) tmo_d = '0;
        else                                           tmo_d = tmo_q + TMO_W'(1);

`ifdef DISPLAY_DP_BLINK_EN
        dp_d = blink_d & ((idx_d == 3'd2) | (idx_d == 3'd4));
`else
        dp_d = 1'b0;
`endif

        // The write fields are loaded on entry to a REQ state and then held,
        // so they are stable from the first strobe cycle until WAIT exits.
        write_config_d = write_config_q;
        digit_d        = digit_q;
        segment_d      = segment_q;
        if (state_d == ST_CFG_REQ) begin
            write_config_d = 1'b1;
        end else if (state_d == ST_DIG_REQ) begin
            write_config_d = 1'b0;
            digit_d        = idx_d;
            segment_d      = {dp_d, 3'b000, pick_nibble(shadow_d, idx_d)};
        end

        stb_d  = (state_d == ST_CFG_REQ) || (state_d == ST_DIG_REQ);
        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: the reset is asynchronous, so the strobe and every other output
    // drop as soon as i_reset_n falls, without waiting for a clock edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q        <= ST_IDLE;
            init_q         <= 1'b0;
            cfg_pend_q     <= 1'b0;
            frame_pend_q   <= 1'b0;
            shadow_q       <= '0;
            idx_q          <= 3'd0;
            tmo_q          <= '0;
            error_q        <= 1'b0;
            stb_q          <= 1'b0;
            busy_q         <= 1'b0;
            write_config_q <= 1'b0;
            digit_q        <= 3'd0;
            segment_q      <= 8'h00;
`ifdef DISPLAY_DP_BLINK_EN
            blink_q        <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments, so every register updates from
            // the same pre-edge values regardless of statement order.
            state_q        <= state_d;
            init_q         <= 1'b1;
            cfg_pend_q     <= cfg_pend_d;
            frame_pend_q   <= frame_pend_d;
            shadow_q       <= shadow_d;
            idx_q          <= idx_d;
            tmo_q          <= tmo_d;
            error_q        <= error_d;
            stb_q          <= stb_d;
            busy_q         <= busy_d;
            write_config_q <= write_config_d;
            digit_q        <= digit_d;
            segment_q      <= segment_d;
`ifdef DISPLAY_DP_BLINK_EN
            blink_q        <= blink_d;
`endif
        end
    end

    assign o_busy         = busy_q;
    assign o_error        = error_q;
    assign o_stb          = stb_q;
    assign o_write_config = write_config_q;
    assign o_digit        = digit_q;
    assign o_segment      = segment_q;

endmodule

// File: tb/tb_max7219_display_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_max7219_display_ctrl
//
// Directed bench for max7219_display_ctrl. A settings-block stub answers each
// strobe with busy/ack. Expected writes are queued when stimulus is applied and
// are checked in order as the stub accepts each write.
// -----------------------------------------------------------------------------
module tb_max7219_display_ctrl;

    localparam int NUM_DIGITS     = 6;
    localparam int TIMEOUT_CYCLES = 255;
`ifdef DISPLAY_DP_BLINK_EN
    localparam logic [7:0] DP_ON = 8'h80;
`else
    localparam logic [7:0] DP_ON = 8'h00;
`endif

    localparam int MODE_OK   = 0;
    localparam int MODE_NACK = 1;
    localparam int MODE_DEAD = 2;

    typedef struct {
        logic       cfg;
        logic [2:0] digit;
        logic [7:0] seg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] time_bcd = 24'h0;
    logic        refresh = 1'b0;
    logic        config_update = 1'b0;
    logic        blink = 1'b0;
    logic        stub_busy = 1'b0;
    logic        stub_ack = 1'b0;
    logic        busy, error, stb, write_config;
    logic [2:0]  digit;
    logic [7:0]  segment;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   stub_mode = MODE_OK;
    int   stub_phase = 0;
    int   stub_hold = 0;
    int   capt_cnt = 0;
    logic [2:0] last_digit = 3'd0;

    max7219_display_ctrl #(
        .NUM_DIGITS     (NUM_DIGITS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .i_clk           (clk),
        .i_reset_n       (rst_n),
        .i_time_bcd      (time_bcd),
        .i_refresh       (refresh),
        .i_config_update (config_update),
        .i_blink         (blink),
        .o_busy          (busy),
        .o_error         (error),
        .o_stb           (stb),
        .i_busy          (stub_busy),
        .i_ack           (stub_ack),
        .o_write_config  (write_config),
        .o_digit         (digit),
        .o_segment       (segment)
    );

    initial forever #10 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_cfg();
        exp_t e;
        e.cfg = 1'b1; e.digit = 3'd0; e.seg = 8'h00;
        sb.push_back(e);
    endtask

    // segs[8k +: 8] is the expected segment byte of digit k.
    task automatic push_frame(input logic [47:0] segs);
        exp_t e;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            e.cfg = 1'b0; e.digit = 3'(k); e.seg = segs[8*k +: 8];
            sb.push_back(e);
        end
    endtask

    task automatic score_write();
        exp_t e;
        check("write_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.cfg) begin
                check("cfg_write", 32'(write_config), 32'd1);
            end else begin
                check($sformatf("digit%0d_write", e.digit),
                      {20'd0, write_config, digit, segment},
                      {20'd0, 1'b0, e.digit, e.seg});
            end
        end
    endtask

    // Settings-block stub: takes the write on a strobe, holds busy for a few
    // cycles, then releases busy with ack (or NACK). MODE_DEAD never answers.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stub_busy  = 1'b0;
                stub_ack   = 1'b0;
                stub_phase = 0;
            end else if (stub_phase == 0) begin
                stub_ack = 1'b0;
                if (stb && stub_mode != MODE_DEAD) begin
                    stub_busy  = 1'b1;
                    capt_cnt++;
                    last_digit = digit;
                    score_write();
                    stub_hold  = 2;
                    stub_phase = 1;
                end
            end else begin
                stub_hold--;
                if (stub_hold == 0) begin
                    stub_busy  = 1'b0;
                    stub_ack   = (stub_mode != MODE_NACK);
                    stub_phase = 0;
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_refresh();
        @(negedge clk); refresh = 1'b1;
        @(negedge clk); refresh = 1'b0;
    endtask

    task automatic pulse_config();
        @(negedge clk); config_update = 1'b1;
        @(negedge clk); config_update = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk); #1;
            done = (sb.size() == 0) && !busy && (stub_phase == 0);
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        if (!done) sb.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},   32'(busy),         32'd0);
        check({tag, "_error"},  32'(error),        32'd0);
        check({tag, "_stb"},    32'(stb),          32'd0);
        check({tag, "_wcfg"},   32'(write_config), 32'd0);
        check({tag, "_digit"},  32'(digit),        32'd0);
        check({tag, "_seg"},    32'(segment),      32'd0);
    endtask

    task automatic release_reset();
        @(negedge clk); #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int  base;
        int  n;
        bit  found;

        // Reset state, then the automatic config write and first frame.
        time_bcd = 24'h123456;
        blink    = 1'b1;
        wait_cycles(3);
        #1;
        check_reset_outputs("reset");
        push_cfg();
        push_frame({8'h01, 8'h02 | DP_ON, 8'h03, 8'h04 | DP_ON, 8'h05, 8'h06});
        release_reset();
        @(negedge clk); #1;
        check("first_stb_cycle1", 32'(stb), 32'd0);
        @(negedge clk); #1;
        check("first_stb_cycle2", 32'(stb), 32'd1);
        check("first_stb_is_cfg", 32'(write_config), 32'd1);
        wait_done("startup");
        check("startup_error", 32'(error), 32'd0);

        // Leading-zero blank on digit 5, plain zeros elsewhere.
        blink    = 1'b0;
        time_bcd = 24'h090500;
        push_frame({8'h0F, 8'h09, 8'h00, 8'h05, 8'h00, 8'h00});
        pulse_refresh();
        wait_done("blank");

        // Requests during a frame coalesce: the current frame keeps its
        // snapshot, then the queued config, then exactly one new frame.
        time_bcd = 24'h654321;
        push_frame({8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01});
        pulse_refresh();
        base = capt_cnt;
        for (int i = 0; i < 100 && capt_cnt < base + 2; i++) @(negedge clk);
        check("midframe_reached", 32'(capt_cnt >= base + 2), 32'd1);
        time_bcd = 24'h000001;
        push_cfg();
        push_frame({8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01});
        pulse_refresh();
        pulse_config();
        wait_cycles(3);
        pulse_refresh();
        check("midframe_still_busy", 32'(busy), 32'd1);
        wait_done("coalesce");
        base = capt_cnt;
        wait_cycles(40);
        check("no_extra_frame", 32'(capt_cnt - base), 32'd0);
        check("no_extra_busy", 32'(busy), 32'd0);
        check("coalesce_error", 32'(error), 32'd0);

        // Settings never answers: strobe times out, error latches.
        stub_mode = MODE_DEAD;
        base = capt_cnt;
        pulse_refresh();
        for (int i = 0; i < 10 && !stb; i++) @(negedge clk);
        check("tmo_stb_rise", 32'(stb), 32'd1);
        n = 0;
        while (stb && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("tmo_cycles", 32'(n >= TIMEOUT_CYCLES && n <= TIMEOUT_CYCLES + 1), 32'd1);
        #1;
        check("tmo_error", 32'(error), 32'd1);
        check("tmo_stb_low", 32'(stb), 32'd0);
        check("tmo_idle", 32'(busy), 32'd0);
        check("tmo_no_write", 32'(capt_cnt - base), 32'd0);

        // A later refresh still runs; 0xA..0xF would not appear here, plain BCD.
        stub_mode = MODE_OK;
        time_bcd  = 24'h105070;
        push_frame({8'h01, 8'h00, 8'h05, 8'h00, 8'h07, 8'h00});
        pulse_refresh();
        wait_done("after_tmo");
        check("error_sticky", 32'(error), 32'd1);

        // Reset while waiting on digit 3, then a full restart.
        time_bcd = 24'h123456;
        blink    = 1'b1;
        push_frame({8'h01, 8'h02 | DP_ON, 8'h03, 8'h04 | DP_ON, 8'h05, 8'h06});
        pulse_refresh();
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk); #1;
            found = (stub_phase == 1) && (last_digit == 3'd3) && !write_config;
        end
        check("digit3_reached", 32'(found), 32'd1);
        @(negedge clk); #1;
        check("dig_wait_stb_low", 32'(stb), 32'd0);
        check("dig_wait_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        sb.delete();
        wait_cycles(3);
        push_cfg();
        push_frame({8'h01, 8'h02 | DP_ON, 8'h03, 8'h04 | DP_ON, 8'h05, 8'h06});
        release_reset();
        wait_done("restart");
        check("restart_error", 32'(error), 32'd0);

        // NACKed writes still complete the frame but set the error;
        // non-BCD nibbles pass through and digit 5 is not blanked.
        stub_mode = MODE_NACK;
        blink     = 1'b0;
        time_bcd  = 24'hABCDEF;
        push_frame({8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F});
        pulse_refresh();
        wait_done("nack");
        check("nack_error", 32'(error), 32'd1);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
